// File: rtl/mem_access_unit_if.sv
// Handshaked data-memory port: request side driven by the access unit, response side by memory.
interface mem_access_unit_if #(
   parameter int DATA_W     = 32,
   parameter int DM_ADDRESS = 9
);
   logic                  m_req;
   logic                  m_we;
   logic [DM_ADDRESS-3:0] m_addr;
   logic [3:0]            m_be;
   logic [DATA_W-1:0]     m_wdata;
   logic                  m_ready;
   logic                  m_rvalid;
   logic [DATA_W-1:0]     m_rdata;

   modport master (
      output m_req, m_we, m_addr, m_be, m_wdata,
      input  m_ready, m_rvalid, m_rdata
   );

   modport slave (
      input  m_req, m_we, m_addr, m_be, m_wdata,
      output m_ready, m_rvalid, m_rdata
   );
endinterface

// File: rtl/mem_access_unit.sv
// Load/store controller: lane-aligns stores, runs the memory handshake, extends loads,
// stalls the pipeline while a transfer is in flight and rejects misaligned/illegal accesses.
module mem_access_unit #(
   parameter int DATA_W     = 32,
   parameter int DM_ADDRESS = 9
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  mem_read,
   input  logic                  mem_write,
   input  logic [DM_ADDRESS-1:0] addr,
   input  logic [DATA_W-1:0]     wr_data,
   input  logic [2:0]            func3,
   output logic [DATA_W-1:0]     load_data,
   output logic                  stall,
   output logic                  access_fault,
   mem_access_unit_if.master     mem
);

   typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} state_t;

   state_t            state;
   logic [1:0]        lat_off;
   logic [2:0]        lat_f3;

   logic              access;
   logic              f3_ok;
   logic              misaligned;
   logic              fault;
   logic              legal;
   logic [3:0]        be_n;
   logic [DATA_W-1:0] wdata_n;
   logic [7:0]        byte_sel;
   logic [15:0]       half_sel;
   logic [DATA_W-1:0] load_ext;

   always_comb begin
      access = mem_read ^ mem_write;
      f3_ok  = 1'b0;
      if (mem_read) begin
         case (func3)
            3'b000, 3'b001, 3'b010, 3'b100, 3'b101: f3_ok = 1'b1;
            default:                                f3_ok = 1'b0;
         endcase
      end else begin
         case (func3)
            3'b000, 3'b001, 3'b010: f3_ok = 1'b1;
            default:                f3_ok = 1'b0;
         endcase
      end
      misaligned = ((func3[1:0] == 2'b01) && addr[0]) ||
                   ((func3[1:0] == 2'b10) && (addr[1:0] != 2'b00));
      // Both strobes high is malformed regardless of func3.
      fault = (mem_read & mem_write) | (access & (~f3_ok | misaligned));
      legal = access & ~fault;
   end

   always_comb begin
      be_n    = 4'b1111;
      wdata_n = wr_data;
      if (mem_write) begin
         case (func3[1:0])
            2'b00: begin
               be_n    = 4'b0001 << addr[1:0];
               wdata_n = {4{wr_data[7:0]}};
            end
            2'b01: begin
               be_n    = addr[1] ? 4'b1100 : 4'b0011;
               wdata_n = {2{wr_data[15:0]}};
            end
            default: begin
               be_n    = 4'b1111;
               wdata_n = wr_data;
            end
         endcase
      end
   end

   always_comb begin
      byte_sel = mem.m_rdata[{lat_off, 3'b000} +: 8];
      half_sel = lat_off[1] ? mem.m_rdata[31:16] : mem.m_rdata[15:0];
      case (lat_f3)
         3'b000:  load_ext = {{24{byte_sel[7]}}, byte_sel};
         3'b001:  load_ext = {{16{half_sel[15]}}, half_sel};
         3'b100:  load_ext = {24'd0, byte_sel};
         3'b101:  load_ext = {16'd0, half_sel};
         default: load_ext = mem.m_rdata;
      endcase
   end

   // Reset dominates: no stall or fault is reported while it is held.
   assign stall        = ~reset & (((state == IDLE) & legal) | (state == REQ) | (state == WAIT));
   assign access_fault = ~reset & (state == IDLE) & fault;

   always_ff @(posedge clk) begin
      if (reset) begin
         state       <= IDLE;
         load_data   <= '0;
         lat_off     <= '0;
         lat_f3      <= '0;
         mem.m_req   <= 1'b0;
         mem.m_we    <= 1'b0;
         mem.m_addr  <= '0;
         mem.m_be    <= '0;
         mem.m_wdata <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (legal) begin
                  mem.m_req   <= 1'b1;
                  mem.m_we    <= mem_write;
                  mem.m_addr  <= addr[DM_ADDRESS-1:2];
                  mem.m_be    <= be_n;
                  mem.m_wdata <= wdata_n;
                  lat_off     <= addr[1:0];
                  lat_f3      <= func3;
                  state       <= REQ;
               end
            end
            REQ: begin
               if (mem.m_ready) begin
                  mem.m_req <= 1'b0;
                  state     <= mem.m_we ? DONE : WAIT;
               end
            end
            WAIT: begin
               if (mem.m_rvalid) begin
                  load_data <= load_ext;
                  state     <= DONE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule
